// File: rtl/id_pipe_if.sv
// Instruction-decode stage stream bundle: IF/ID-side input handshake and ID/EX-side output register.
// slave is the decode stage itself; master is whoever sits on both sides of it (fetch and execute).
interface id_pipe_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       pc_o;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic              is_load_o;
  logic              instvalid_o;

  modport slave (
    input  in_valid, pc_i, inst_i, out_ready,
    output in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, instvalid_o
  );

  modport master (
    output in_valid, pc_i, inst_i, out_ready,
    input  in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, instvalid_o
  );
endinterface

// File: rtl/id_pipe.sv
// Registered decode stage for logic-imm, logic-reg and LW instructions with operand
// forwarding, load-use stall detection and a one-entry valid/ready output register.
module id_pipe #(
  parameter int DATA_W    = 32,
  parameter int FWD_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  id_pipe_if.slave                      bus,
  output logic                          reg1_read_o,
  output logic                          reg2_read_o,
  output logic [4:0]                    reg1_addr_o,
  output logic [4:0]                    reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_we_i,
  input  logic [5*FWD_PORTS-1:0]        fwd_waddr_i,
  input  logic [DATA_W*FWD_PORTS-1:0]   fwd_wdata_i,
  input  logic                          ex_is_load_i,
  input  logic [4:0]                    ex_wd_i,
  input  logic                          flush_i,
  output logic [15:0]                   stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic              dec_r1rd;
  logic              dec_r2rd;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_wd;
  logic              dec_wreg;
  logic              dec_load;
  logic              dec_valid;

  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;
  logic              hazard;
  logic              capture;

  logic              out_valid_q;
  logic [31:0]       pc_q;
  logic [7:0]        aluop_q;
  logic [2:0]        alusel_q;
  logic [DATA_W-1:0] reg1_q;
  logic [DATA_W-1:0] reg2_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              is_load_q;
  logic              instvalid_q;
  logic [15:0]       stall_cnt_q;

  assign op    = bus.inst_i[31:26];
  assign funct = bus.inst_i[5:0];
  assign imm16 = bus.inst_i[15:0];
  assign rs    = bus.inst_i[25:21];
  assign rt    = bus.inst_i[20:16];
  assign rd    = bus.inst_i[15:11];

  always_comb begin
    dec_r1rd   = 1'b0;
    dec_r2rd   = 1'b0;
    dec_aluop  = EXE_NOP_OP;
    dec_alusel = EXE_RES_NOP;
    dec_imm    = '0;
    dec_wd     = 5'd0;
    dec_wreg   = 1'b0;
    dec_load   = 1'b0;
    dec_valid  = 1'b0;
    unique case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_r1rd   = 1'b1;
        dec_alusel = EXE_RES_LOGIC;
        dec_imm    = {{(DATA_W-16){1'b0}}, imm16};
        dec_wd     = rt;
        dec_wreg   = 1'b1;
        dec_valid  = 1'b1;
        dec_aluop  = (op == OP_ORI)  ? EXE_OR_OP  :
                     (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
      end
      OP_LUI: begin
        dec_aluop  = EXE_OR_OP;
        dec_alusel = EXE_RES_LOGIC;
        dec_imm    = DATA_W'({imm16, 16'h0000});
        dec_wd     = rt;
        dec_wreg   = 1'b1;
        dec_valid  = 1'b1;
      end
      OP_LW: begin
        dec_r1rd   = 1'b1;
        dec_aluop  = EXE_LW_OP;
        dec_alusel = EXE_RES_LOAD_STORE;
        dec_imm    = {{(DATA_W-16){imm16[15]}}, imm16};
        dec_wd     = rt;
        dec_wreg   = 1'b1;
        dec_load   = 1'b1;
        dec_valid  = 1'b1;
      end
      OP_SPECIAL: begin
        // Only the four logic functs are legal; anything else falls out as illegal.
        if (funct == FN_OR || funct == FN_AND || funct == FN_XOR || funct == FN_NOR) begin
          dec_r1rd   = 1'b1;
          dec_r2rd   = 1'b1;
          dec_alusel = EXE_RES_LOGIC;
          dec_wd     = rd;
          dec_wreg   = 1'b1;
          dec_valid  = 1'b1;
          unique case (funct)
            FN_OR:   dec_aluop = EXE_OR_OP;
            FN_AND:  dec_aluop = EXE_AND_OP;
            FN_XOR:  dec_aluop = EXE_XOR_OP;
            default: dec_aluop = EXE_NOR_OP;
          endcase
        end
      end
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] sel_operand(
    input logic                        rd_en,
    input logic [4:0]                  addr,
    input logic [DATA_W-1:0]           rf_data,
    input logic [DATA_W-1:0]           alt,
    input logic [FWD_PORTS-1:0]        we,
    input logic [5*FWD_PORTS-1:0]      waddr,
    input logic [DATA_W*FWD_PORTS-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    v = rf_data;
    // Walk from oldest to youngest so the lowest-index match overwrites the rest.
    for (int k = FWD_PORTS - 1; k >= 0; k--) begin
      if (we[k] && waddr[5*k +: 5] == addr) v = wdata[DATA_W*k +: DATA_W];
    end
    if (!rd_en)          return alt;
    else if (addr == '0) return '0;
    else                 return v;
  endfunction

  always_comb begin
    opnd1 = sel_operand(dec_r1rd, rs, reg1_data_i, '0, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
    opnd2 = sel_operand(dec_r2rd, rt, reg2_data_i, dec_imm, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
  end

  assign hazard = bus.in_valid && ex_is_load_i && (ex_wd_i != 5'd0) &&
                  ((dec_r1rd && rs == ex_wd_i) || (dec_r2rd && rt == ex_wd_i));

  assign bus.in_ready = rst && !flush_i && !hazard && (!out_valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  assign reg1_read_o = rst && dec_r1rd;
  assign reg2_read_o = rst && dec_r2rd;
  assign reg1_addr_o = rst ? rs : 5'd0;
  assign reg2_addr_o = rst ? rt : 5'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= EXE_NOP_OP;
      alusel_q    <= EXE_RES_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      is_load_q   <= 1'b0;
      instvalid_q <= 1'b1;
      stall_cnt_q <= 16'd0;
    end else begin
      if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (capture) begin
        out_valid_q <= 1'b1;
        pc_q        <= bus.pc_i;
        aluop_q     <= dec_aluop;
        alusel_q    <= dec_alusel;
        reg1_q      <= opnd1;
        reg2_q      <= opnd2;
        wd_q        <= dec_wd;
        wreg_q      <= dec_wreg;
        is_load_q   <= dec_load;
        instvalid_q <= dec_valid;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.pc_o        = pc_q;
  assign bus.aluop_o     = aluop_q;
  assign bus.alusel_o    = alusel_q;
  assign bus.reg1_o      = reg1_q;
  assign bus.reg2_o      = reg2_q;
  assign bus.wd_o        = wd_q;
  assign bus.wreg_o      = wreg_q;
  assign bus.is_load_o   = is_load_q;
  assign bus.instvalid_o = instvalid_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: table of single-instruction decodes, then hand sequences
// for load-use stall, hold, flush and reset-during-hold.
module tb_id_pipe;
  localparam int DATA_W    = 32;
  localparam int FWD_PORTS = 2;

  localparam logic [7:0] NOP = 8'h00, AND = 8'h24, OR = 8'h25, XOR = 8'h26, NOR = 8'h27, LW = 8'hE3;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_LS = 3'd7;

  logic clk;
  logic rst;
  logic reg1_read_o, reg2_read_o;
  logic [4:0] reg1_addr_o, reg2_addr_o;
  logic [DATA_W-1:0] reg1_data_i, reg2_data_i;
  logic [FWD_PORTS-1:0] fwd_we_i;
  logic [5*FWD_PORTS-1:0] fwd_waddr_i;
  logic [DATA_W*FWD_PORTS-1:0] fwd_wdata_i;
  logic ex_is_load_i;
  logic [4:0] ex_wd_i;
  logic flush_i;
  logic [15:0] stall_cnt_o;

  id_pipe_if #(.DATA_W(DATA_W)) bus ();

  id_pipe #(.DATA_W(DATA_W), .FWD_PORTS(FWD_PORTS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i), .flush_i(flush_i),
    .stall_cnt_o(stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [1:0]  fwe;
    logic [9:0]  fwa;
    logic [63:0] fwd;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        ld;
    logic        iv;
    logic        r1rd;
    logic        r2rd;
  } vec_t;

  vec_t vecs[10];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " pc_o"}, bus.pc_o, 0);
    chk({tag, " aluop_o"}, bus.aluop_o, NOP);
    chk({tag, " alusel_o"}, bus.alusel_o, S_NOP);
    chk({tag, " reg1_o"}, bus.reg1_o, 0);
    chk({tag, " reg2_o"}, bus.reg2_o, 0);
    chk({tag, " wd_o"}, bus.wd_o, 0);
    chk({tag, " wreg_o"}, bus.wreg_o, 0);
    chk({tag, " is_load_o"}, bus.is_load_o, 0);
    chk({tag, " instvalid_o"}, bus.instvalid_o, 1);
    chk({tag, " stall_cnt_o"}, stall_cnt_o, 0);
  endtask

  initial begin
    vecs[0] = '{32'h3421_1234, 32'h0000_FF00, 32'h0, 2'b00, {5'd0, 5'd0}, 64'h0,
                OR, S_LOG, 32'h0000_FF00, 32'h0000_1234, 5'd1, 1, 0, 1, 1, 0};
    vecs[1] = '{32'h0022_1825, 32'h11, 32'h77, 2'b11, {5'd1, 5'd1}, {32'h5555_0000, 32'hAAAA_0000},
                OR, S_LOG, 32'hAAAA_0000, 32'h77, 5'd3, 1, 0, 1, 1, 1};
    vecs[2] = '{32'h8C22_FFFC, 32'h1000, 32'h0, 2'b00, {5'd0, 5'd0}, 64'h0,
                LW, S_LS, 32'h1000, 32'hFFFF_FFFC, 5'd2, 1, 1, 1, 1, 0};
    vecs[3] = '{32'h3042_00FF, 32'h22, 32'h0, 2'b11, {5'd2, 5'd5}, {32'h1234_5678, 32'h0BAD_0BAD},
                AND, S_LOG, 32'h1234_5678, 32'hFF, 5'd2, 1, 0, 1, 1, 0};
    vecs[4] = '{32'h3800_ABCD, 32'hDEAD_BEEF, 32'h0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h7777_7777},
                XOR, S_LOG, 32'h0, 32'h0000_ABCD, 5'd0, 1, 0, 1, 1, 0};
    vecs[5] = '{32'h3C05_8001, 32'hFFFF_FFFF, 32'h0, 2'b00, {5'd0, 5'd0}, 64'h0,
                OR, S_LOG, 32'h0, 32'h8001_0000, 5'd5, 1, 0, 1, 0, 0};
    vecs[6] = '{32'h0085_3027, 32'h0F0F_0F0F, 32'h00FF_00FF, 2'b10, {5'd5, 5'd0}, {32'h1111_1111, 32'h0},
                NOR, S_LOG, 32'h0F0F_0F0F, 32'h1111_1111, 5'd6, 1, 0, 1, 1, 1};
    vecs[7] = '{32'h00E8_4824, 32'h7, 32'h8000_0000, 2'b00, {5'd0, 5'd7}, {32'h0, 32'hCAFE},
                AND, S_LOG, 32'h7, 32'h8000_0000, 5'd9, 1, 0, 1, 1, 1};
    vecs[8] = '{32'hFFFF_FFFF, 32'h5, 32'h6, 2'b00, {5'd0, 5'd0}, 64'h0,
                NOP, S_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0};
    vecs[9] = '{32'h0022_1820, 32'h5, 32'h6, 2'b00, {5'd0, 5'd0}, 64'h0,
                NOP, S_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0};

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.pc_i = '0; bus.inst_i = '0; bus.out_ready = 1'b1;
    reg1_data_i = '0; reg2_data_i = '0;
    fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
    ex_is_load_i = 1'b0; ex_wd_i = '0; flush_i = 1'b0;

    // Reset: combinational regfile outputs and in_ready held low even with a valid ORI present.
    tick(); tick();
    bus.inst_i = 32'h3421_1234; bus.in_valid = 1'b1;
    #1;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst reg1_read_o", reg1_read_o, 0);
    chk("rst reg1_addr_o", reg1_addr_o, 0);
    chk("rst reg2_addr_o", reg2_addr_o, 0);
    tick();
    chk_reset_state("rst");
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      bus.inst_i = vecs[i].inst; bus.pc_i = 32'h100 + 32'(4 * i);
      reg1_data_i = vecs[i].r1d; reg2_data_i = vecs[i].r2d;
      fwd_we_i = vecs[i].fwe; fwd_waddr_i = vecs[i].fwa; fwd_wdata_i = vecs[i].fwd;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), bus.in_ready, 1);
      chk($sformatf("v%0d reg1_read_o", i), reg1_read_o, vecs[i].r1rd);
      chk($sformatf("v%0d reg2_read_o", i), reg2_read_o, vecs[i].r2rd);
      tick();
      chk($sformatf("v%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d pc_o", i), bus.pc_o, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d aluop_o", i), bus.aluop_o, vecs[i].aluop);
      chk($sformatf("v%0d alusel_o", i), bus.alusel_o, vecs[i].alusel);
      chk($sformatf("v%0d reg1_o", i), bus.reg1_o, vecs[i].reg1);
      chk($sformatf("v%0d reg2_o", i), bus.reg2_o, vecs[i].reg2);
      chk($sformatf("v%0d wd_o", i), bus.wd_o, vecs[i].wd);
      chk($sformatf("v%0d wreg_o", i), bus.wreg_o, vecs[i].wreg);
      chk($sformatf("v%0d is_load_o", i), bus.is_load_o, vecs[i].ld);
      chk($sformatf("v%0d instvalid_o", i), bus.instvalid_o, vecs[i].iv);
    end
    fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;

    // Load-use: LW $2 in EX, OR reading $2 stalls one cycle.
    bus.inst_i = 32'h8C22_FFFC; reg1_data_i = 32'h1000;
    tick();
    chk("lu lw is_load_o", bus.is_load_o, 1);
    bus.inst_i = 32'h0022_1825; reg1_data_i = 32'h1; reg2_data_i = 32'h2;
    ex_is_load_i = 1'b1; ex_wd_i = 5'd2;
    #1;
    chk("lu stall in_ready", bus.in_ready, 0);
    chk("lu reg2_addr_o", reg2_addr_o, 2);
    tick();
    chk("lu stall_cnt", stall_cnt_o, 1);
    chk("lu drained out_valid", bus.out_valid, 0);
    ex_is_load_i = 1'b0;
    #1;
    chk("lu resume in_ready", bus.in_ready, 1);
    tick();
    chk("lu or out_valid", bus.out_valid, 1);
    chk("lu or wd_o", bus.wd_o, 3);
    chk("lu or reg2_o", bus.reg2_o, 2);
    chk("lu stall_cnt held", stall_cnt_o, 1);

    // Hold the OR entry for three cycles, then release and capture a new ORI.
    bus.out_ready = 1'b0;
    bus.inst_i = 32'h3421_0055; reg1_data_i = 32'h99;
    #1;
    chk("hold in_ready", bus.in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d out_valid", c), bus.out_valid, 1);
      chk($sformatf("hold%0d wd_o", c), bus.wd_o, 3);
      chk($sformatf("hold%0d reg1_o", c), bus.reg1_o, 1);
      chk($sformatf("hold%0d reg2_o", c), bus.reg2_o, 2);
      chk($sformatf("hold%0d in_ready", c), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", bus.in_ready, 1);
    tick();
    chk("release wd_o", bus.wd_o, 1);
    chk("release reg1_o", bus.reg1_o, 32'h99);
    chk("release reg2_o", bus.reg2_o, 32'h55);

    // Flush during a hold, coinciding with a load-use hazard: entry dropped, counter still counts.
    bus.out_ready = 1'b0;
    bus.inst_i = 32'h0022_1825;
    ex_is_load_i = 1'b1; ex_wd_i = 5'd1;
    flush_i = 1'b1;
    #1;
    chk("flush in_ready", bus.in_ready, 0);
    tick();
    chk("flush out_valid", bus.out_valid, 0);
    chk("flush stall_cnt", stall_cnt_o, 2);
    flush_i = 1'b0; ex_is_load_i = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("post flush out_valid", bus.out_valid, 0);

    // Reset while an LW entry is held.
    bus.inst_i = 32'h8C22_FFFC; bus.pc_i = 32'h200; reg1_data_i = 32'h4000;
    bus.in_valid = 1'b1;
    tick();
    chk("mr capture out_valid", bus.out_valid, 1);
    chk("mr capture is_load_o", bus.is_load_o, 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk_reset_state("mr");
    rst = 1'b1;
    tick();
    chk("mr after out_valid", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, parametrised instruction-decode stage sitting between the IF/ID boundary and EX. It decodes the logic-immediate, logic-register and load instructions into ALU op/select, operands and write-back target. It forwards operands from up to FWD_PORTS later stages, detects load-use hazards, and presents results through a one-entry valid/ready pipeline register with flush support. A saturating stall counter is kept for performance monitoring.

## Interface
- DATA_W, 32: operand/result width; must be ≥ 32; immediates extend to DATA_W.
- FWD_PORTS, 2: number of forwarding sources; index 0 has highest priority (youngest stage).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low (state cleared on a rising edge with rst == 0).
- in_valid  in  1  pc_i/inst_i valid.
- in_ready  out  1  stage accepts the input this cycle.
- pc_i  in  `InstAddrBus` width  instruction address.
- inst_i  in  `InstBus` width  instruction word.
- reg1_read_o, reg2_read_o  out  1 each  combinational regfile read enables.
- reg1_addr_o, reg2_addr_o  out  5 each  combinational: inst_i[25:21] and inst_i[20:16].
- reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data (same cycle).
- fwd_we_i  in  FWD_PORTS  forward-source write enables.
- fwd_waddr_i  in  5*FWD_PORTS  forward-source destination addresses; port k occupies bits [5k+4:5k].
- fwd_wdata_i  in  DATA_W*FWD_PORTS  forward-source data; port k occupies bits [DATA_W*k+DATA_W-1:DATA_W*k].
- ex_is_load_i  in  1  instruction now in EX is a load.
- ex_wd_i  in  5  destination register of that EX instruction.
- flush_i  in  1  discard the pipeline register and the current input.
- out_valid  out  1  registered outputs valid.
- out_ready  in  1  EX accepts the outputs.
- pc_o  out  `InstAddrBus` width  registered.
- aluop_o, alusel_o  out  `AluOpBus`/`AluSelBus` widths  registered.
- reg1_o, reg2_o  out  DATA_W each  registered operands.
- wd_o  out  5  registered write-back address.
- wreg_o  out  1  registered write enable.
- is_load_o  out  1  registered load flag.
- instvalid_o  out  1  registered; 0 for an illegal instruction.
- stall_cnt_o  out  16  load-use stall cycles, saturating.

## Operation
- Decode uses op = inst[31:26] and funct = inst[5:0]. The immediate is imm16 = inst[15:0].
- ORI (001101), ANDI (001100), XORI (001110):
  - aluop is EXE_OR_OP, EXE_AND_OP or EXE_XOR_OP respectively; alusel EXE_RES_LOGIC.
  - reg1 is read; reg2 = zero-extended imm16; wd = inst[20:16]; wreg = 1.
- LUI (001111): reg1 not read, reg1 = 0; reg2 = {imm16, 16'h0} zero-extended; aluop EXE_OR_OP; wd = inst[20:16]; wreg = 1.
- SPECIAL (000000) with funct OR (100101), AND (100100), XOR (100110), NOR (100111):
  - Both registers read; wd = inst[15:11]; wreg = 1; alusel EXE_RES_LOGIC.
- LW (100011):
  - reg1 = base register; reg2 = sign-extended imm16; aluop EXE_LW_OP; alusel EXE_RES_LOAD_STORE.
  - wd = inst[20:16]; wreg = 1; is_load = 1.
- Any other encoding: instvalid = 0, wreg = 0, aluop EXE_NOP_OP, alusel EXE_RES_NOP. It still flows with out_valid = 1 so a later stage can raise the exception.
- Operand select, for each read operand:
  - If the address is 0, the operand is 0.
  - Otherwise use the lowest-index port k with fwd_we_i[k] = 1 and a matching address.
  - Otherwise use regfile data.
  - A non-read operand takes the immediate (or 0 for LUI reg1).
- Load-use hazard:
  - Condition: in_valid, ex_is_load_i, ex_wd_i ≠ 0, and a read operand address equal to ex_wd_i.
  - Effect: in_ready = 0.
- in_ready = rst & !flush_i & !hazard & (!out_valid | out_ready).
- stall_cnt_o increments in every cycle the hazard holds. It saturates at 16'hFFFF.

## Timing
- Latency is 1 cycle. When in_valid & in_ready, the decoded result is registered and out_valid = 1 on the next edge.
- Hold: while out_valid & !out_ready, all registered outputs stay stable.
- Drain: out_ready with no new capture clears out_valid on the next edge.
- Flush: flush_i clears out_valid on the next edge. The input is dropped. flush_i has priority over capture, hold and hazard.
- Reset: rst == 0 at an edge clears every registered output:
  - out_valid, pc_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o and stall_cnt_o become 0.
  - aluop_o becomes EXE_NOP_OP; alusel_o becomes EXE_RES_NOP; instvalid_o becomes 1.
  - Reset mid-stall or mid-hold discards the held entry.
- While rst == 0:
  - in_ready = 0.
  - Combinational regfile outputs are 0 (read enables and addresses).
- Hazard and flush in the same cycle: no capture, and the counter still increments.
- Forwarding is combinational from fwd_* into the captured operands, so it takes effect in the capture cycle only.

## Test plan
- Reset, then ORI inst 32'h3421_1234 with reg1_data_i = 32'h0000_FF00 → next cycle:
  - out_valid = 1, aluop_o = EXE_OR_OP, reg1_o = 32'h0000_FF00, reg2_o = 32'h0000_1234, wd_o = 1, wreg_o = 1.
- OR $3,$1,$2 (32'h0022_1825) with fwd port0 writing $1 = 32'hAAAA_0000 and port1 writing $1 = 32'h5555_0000 → reg1_o = 32'hAAAA_0000 (port 0 wins).
- LW 32'h8C22_FFFC → reg2_o = 32'hFFFF_FFFC, is_load_o = 1, wd_o = 2. Then present OR using $2 with ex_is_load_i = 1 and ex_wd_i = 2 for 1 cycle → in_ready = 0 for 1 cycle and stall_cnt_o = 1.
- Hold 3 cycles with out_ready = 0 → outputs unchanged, in_ready = 0. Then out_ready = 1 → next input is captured the following cycle.
- flush_i during a valid hold → out_valid = 0 next cycle. Illegal opcode 6'b111111 → out_valid = 1, instvalid_o = 0, wreg_o = 0.
- Assert rst = 0 mid-hold → all outputs take their reset values at the next edge, and stall_cnt_o = 0.
